blockc_see_tx: RTL and testbench

BLOCKC_SEE_TX -- requirements
Module: blockc_see_tx

---
 rtl/blockc_see_tx_if.sv | 11 +
 rtl/blockc_see_tx.sv | 90 +++++++++
 tb/tb_blockc_see_tx.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/blockc_see_tx_if.sv
// Valid/ready handshake channel: the source drives vld/data, the sink answers with rdy.
interface rdy_vld_if #(
  parameter int DATA_W = 32
);
  logic              vld;
  logic              rdy;
  logic [DATA_W-1:0] data;

  modport src (output vld, output data, input rdy);
  modport dst (input vld, input data, output rdy);
endinterface

// File: rtl/blockc_see_tx.sv
// Buffered transmitter: a local producer fills a circular buffer that is drained
// over the see valid/ready channel, gated by en, with a running transfer count.
module blockc_see_tx #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  rdy_vld_if.src                   see,
  input  logic                     in_vld,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_rdy,
  input  logic                     en,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              sent_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [15:0]       sent_q, sent_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic push;
  logic pop;

  assign in_rdy   = (level_q != LW'(DEPTH));
  assign push     = in_vld && in_rdy;
  assign pop      = (state_q == PRESENT) && see.rdy;
  assign level    = level_q;
  assign sent_cnt = sent_q;

  // The head entry cannot be overwritten while presented (writes only land
  // in free slots), so driving data straight from the array keeps it stable.
  assign see.vld  = (state_q == PRESENT);
  assign see.data = (state_q == PRESENT) ? mem[rptr_q] : '0;

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    sent_d  = sent_q;

    if (push) wptr_d = wptr_q + 1'b1;
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
      sent_d = sent_q + 16'd1;
    end
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (!push && pop) level_d = level_q - 1'b1;

    case (state_q)
      IDLE: begin
        if (en && (level_q != '0)) state_d = PRESENT;
      end
      PRESENT: begin
        if (see.rdy && (((level_q == LW'(1)) && !push) || !en)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      sent_q  <= sent_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= in_data;
  end

endmodule

// File: tb/tb_blockc_see_tx.sv
// Scoreboard bench for blockc_see_tx: accepted pushes queue expected words, a
// negedge monitor checks every see handshake in order and hold stability.
module tb_blockc_see_tx;

  logic        clk;
  logic        rst_n;
  logic        in_vld;
  logic [31:0] in_data;
  logic        in_rdy;
  logic        en;
  logic [2:0]  level;
  logic [15:0] sent_cnt;
  logic        see_rdy;

  rdy_vld_if #(.DATA_W(32)) see_if ();
  assign see_if.rdy = see_rdy;

  blockc_see_tx #(.DATA_W(32), .DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .see      (see_if),
    .in_vld   (in_vld),
    .in_data  (in_data),
    .in_rdy   (in_rdy),
    .en       (en),
    .level    (level),
    .sent_cnt (sent_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: ordered data on every handshake, and vld/data held while stalled.
  logic        hold;
  logic [31:0] hold_data;
  initial hold = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        total++;
        if (!(see_if.vld === 1'b1 && see_if.data === hold_data)) begin
          bad++;
          $display("FAIL hold_stable: got vld=%b data=%h want vld=1 data=%h at %0t",
                   see_if.vld, see_if.data, hold_data, $time);
        end
      end
      if (see_if.vld === 1'b1 && see_rdy === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL xfer_unexpected: got data=%h want no transfer at %0t", see_if.data, $time);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (see_if.data !== e) begin
            bad++;
            $display("FAIL xfer_data: got %h want %h at %0t", see_if.data, e, $time);
          end
        end
      end
      hold      = (see_if.vld === 1'b1) && (see_rdy !== 1'b1);
      hold_data = see_if.data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    in_vld  = 1'b0;
    in_data = '0;
    see_rdy = 1'b0;
    en      = 1'b0;
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic push1(input logic [31:0] d, input logic acc);
    in_vld  = 1'b1;
    in_data = d;
    chk("in_rdy_at_push", {31'd0, in_rdy}, {31'd0, acc});
    if (acc) exp_q.push_back(d);
    step();
    in_vld = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    see_rdy = 1'b1;
    while (exp_q.size() != 0 && guard < 40) begin
      step();
      guard++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    step();
    chk("drain_vld", {31'd0, see_if.vld}, 32'd0);
    chk("drain_level", {29'd0, level}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("rst_vld", {31'd0, see_if.vld}, 32'd0);
    chk("rst_data", see_if.data, 32'd0);
    chk("rst_level", {29'd0, level}, 32'd0);
    chk("rst_sent", {16'd0, sent_cnt}, 32'd0);
    chk("rst_in_rdy", {31'd0, in_rdy}, 32'd1);

    // Single word, minimum latency
    en = 1'b1; see_rdy = 1'b1;
    push1(32'hA5A5_A5A5, 1'b1);
    chk("single_vld_n", {31'd0, see_if.vld}, 32'd0);
    chk("single_level_n", {29'd0, level}, 32'd1);
    step();
    chk("single_vld_n1", {31'd0, see_if.vld}, 32'd1);
    chk("single_data_n1", see_if.data, 32'hA5A5_A5A5);
    step();
    chk("single_sent", {16'd0, sent_cnt}, 32'd1);
    chk("single_level", {29'd0, level}, 32'd0);
    chk("single_idle", {31'd0, see_if.vld}, 32'd0);

    // Backpressure
    do_reset();
    en = 1'b1;
    for (int i = 1; i <= 4; i++) push1(32'(i), 1'b1);
    chk("bp_level", {29'd0, level}, 32'd4);
    chk("bp_in_rdy", {31'd0, in_rdy}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      chk("bp_data_hold", see_if.data, 32'd1);
      step();
    end
    see_rdy = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("bp_sent", {16'd0, sent_cnt}, 32'd4);
    chk("bp_level_end", {29'd0, level}, 32'd0);
    chk("bp_idle", {31'd0, see_if.vld}, 32'd0);

    // Full buffer with simultaneous pop rejects the push
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 4; i++) push1(32'h10 + 32'(i), 1'b1);
    see_rdy = 1'b1;
    push1(32'h99, 1'b0);
    see_rdy = 1'b0;
    chk("full_level", {29'd0, level}, 32'd3);
    chk("full_in_rdy", {31'd0, in_rdy}, 32'd1);
    chk("full_next_data", see_if.data, 32'h11);
    drain();

    // en gating
    do_reset();
    push1(32'h20, 1'b1);
    push1(32'h21, 1'b1);
    chk("en_level", {29'd0, level}, 32'd2);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("en_off_vld", {31'd0, see_if.vld}, 32'd0);
    end
    en = 1'b1;
    step();
    chk("en_on_vld", {31'd0, see_if.vld}, 32'd1);
    chk("en_on_data", see_if.data, 32'h20);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("en_drop_vld_held", {31'd0, see_if.vld}, 32'd1);
    end
    see_rdy = 1'b1;
    step();
    chk("en_drop_idle", {31'd0, see_if.vld}, 32'd0);
    chk("en_drop_level", {29'd0, level}, 32'd1);
    chk("en_drop_sent", {16'd0, sent_cnt}, 32'd1);
    step();
    chk("en_drop_still_idle", {31'd0, see_if.vld}, 32'd0);
    en = 1'b1;
    step();
    chk("en_again_data", see_if.data, 32'h21);
    step();
    chk("en_again_sent", {16'd0, sent_cnt}, 32'd2);
    chk("en_again_idle", {31'd0, see_if.vld}, 32'd0);

    // Counter and pointer wrap
    do_reset();
    en = 1'b1; see_rdy = 1'b1;
    for (int i = 0; i < 32'hFFFE; i++) push1(32'h1000_0000 + 32'(i), 1'b1);
    drain();
    chk("wrap_sent_fffe", {16'd0, sent_cnt}, 32'h0000_FFFE);
    see_rdy = 1'b0;
    for (int i = 0; i < 3; i++) push1(32'hC0 + 32'(i), 1'b1);
    drain();
    chk("wrap_sent_0001", {16'd0, sent_cnt}, 32'h0000_0001);
    see_rdy = 1'b0;
    for (int b = 0; b < 3; b++) begin
      see_rdy = 1'b0;
      for (int i = 0; i < 4; i++) push1(32'hB00 + 32'(b * 4 + i), 1'b1);
      drain();
    end
    chk("wrap_sent_burst", {16'd0, sent_cnt}, 32'd13);

    // Reset mid-transfer
    do_reset();
    en = 1'b1;
    push1(32'h55, 1'b1);
    push1(32'h66, 1'b1);
    chk("mid_vld", {31'd0, see_if.vld}, 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    step();
    rst_n = 1'b1;
    chk("mid_rst_vld", {31'd0, see_if.vld}, 32'd0);
    chk("mid_rst_level", {29'd0, level}, 32'd0);
    chk("mid_rst_sent", {16'd0, sent_cnt}, 32'd0);
    chk("mid_rst_in_rdy", {31'd0, in_rdy}, 32'd1);
    see_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_rst_stays_idle", {31'd0, see_if.vld}, 32'd0);
    end
    chk("mid_rst_sent_end", {16'd0, sent_cnt}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
